// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Marks a source operand that the D-stage instruction does not read.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Width and load values of the mult/div occupancy counter.
  localparam int                  MD_CNT_W    = 4;
  localparam logic [MD_CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [MD_CNT_W-1:0] DIV_CYCLES  = 4'd10;

  // Pipeline control action chosen each cycle, in priority order flush > stall > run.
  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_STALL,
    CTRL_FLUSH
  } ctrl_e;

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads on issue, counts down to idle.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic respon,
  output logic busy
);

  logic [MD_CNT_W-1:0] cnt;

  // Load on a surviving issue, otherwise count down; a new issue always reloads.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt <= '0;
    end else if (start && !respon) begin
      cnt <= div ? DIV_CYCLES : MULT_CYCLES;
    end else if (cnt != '0) begin
      cnt <= cnt - MD_CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load/use and mult/div stalls plus exception flushes.
// Optional feature macro: HAZARD_CTRL_MDU_EN enables the mult/div busy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] tuseRsD,
  input  logic [1:0] tuseRtD,
  input  logic [4:0] A3E,
  input  logic [4:0] A3M,
  input  logic [1:0] tnewE,
  input  logic [1:0] tnewM,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       mdStartE,
  input  logic       mdDivE,
  input  logic       mdUseD,
  input  logic       respon,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       mdBusy
);

  logic  haz_rs, haz_rt, haz_md, md_busy_raw;
  ctrl_e action;

  // A source hazard exists when a later-stage writer will not have its result
  // ready by the time the D instruction needs it; r0 never carries a dependency.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3e,
    input logic [1:0] tne,
    input logic       we_e,
    input logic [4:0] a3m,
    input logic [1:0] tnm,
    input logic       we_m
  );
    return (tuse != TUSE_NONE) && (src != 5'd0) &&
           ((we_e && (a3e == src) && (tne > tuse)) ||
            (we_m && (a3m == src) && (tnm > tuse)));
  endfunction

  assign haz_rs = src_hazard(rsD, tuseRsD, A3E, tnewE, RegWriteE, A3M, tnewM, RegWriteM);
  assign haz_rt = src_hazard(rtD, tuseRtD, A3E, tnewE, RegWriteE, A3M, tnewM, RegWriteM);

`ifdef HAZARD_CTRL_MDU_EN
  md_busy_cnt u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (mdStartE),
    .div    (mdDivE),
    .respon (respon),
    .busy   (md_busy_raw)
  );

  assign haz_md = mdUseD && (md_busy_raw || mdStartE);
`else
  logic unused_md;

  assign unused_md   = ^{mdStartE, mdDivE, mdUseD};
  assign md_busy_raw = 1'b0;
  assign haz_md      = 1'b0;
`endif

  // The counter clears on the reset edge; mask it so busy already reads 0 during reset.
  assign mdBusy = md_busy_raw && !reset;

  // Pick the pipeline action (reset and exceptions dominate stalls) and decode it.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    action = CTRL_RUN;
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;

    if (reset || respon) begin
      action = CTRL_FLUSH;
    end else if (haz_rs || haz_rt || haz_md) begin
      action = CTRL_STALL;
    end

    case (action)
      CTRL_STALL: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      CTRL_FLUSH: begin
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; adapts to HAZARD_CTRL_MDU_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  // Output vector order: {stallF, stallD, flushD, flushE, flushM, mdBusy}
  localparam logic [5:0] O_RUN   = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b110100;
  localparam logic [5:0] O_FLUSH = 6'b001110;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, A3E, A3M;
  logic [1:0] tuseRsD, tuseRtD, tnewE, tnewM;
  logic       RegWriteE, RegWriteM, mdStartE, mdDivE, mdUseD, respon;
  logic       stallF, stallD, flushD, flushE, flushM, mdBusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rsD       (rsD),
    .rtD       (rtD),
    .tuseRsD   (tuseRsD),
    .tuseRtD   (tuseRtD),
    .A3E       (A3E),
    .A3M       (A3M),
    .tnewE     (tnewE),
    .tnewM     (tnewM),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .mdStartE  (mdStartE),
    .mdDivE    (mdDivE),
    .mdUseD    (mdUseD),
    .respon    (respon),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .flushE    (flushE),
    .flushM    (flushM),
    .mdBusy    (mdBusy)
  );

  function automatic logic [5:0] outs();
    return {stallF, stallD, flushD, flushE, flushM, mdBusy};
  endfunction

  function automatic logic [5:0] with_busy(input logic [5:0] base, input bit busy);
    return {base[5:1], busy};
  endfunction

  task automatic idle_inputs();
    rsD = 5'd0; rtD = 5'd0; tuseRsD = 2'd3; tuseRtD = 2'd3;
    A3E = 5'd0; A3M = 5'd0; tnewE = 2'd0; tnewM = 2'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0;
    mdStartE = 1'b0; mdDivE = 1'b0; mdUseD = 1'b0; respon = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    // Hazard present during reset must not stall.
    rsD = 5'd5; tuseRsD = 2'd0; A3E = 5'd5; tnewE = 2'd2; RegWriteE = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), O_FLUSH);
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", outs(), O_RUN);
    end
  endtask

  typedef struct {
    logic [4:0] rs, rt, a3e, a3m;
    logic [1:0] trs, trt, tne, tnm;
    logic       we_e, we_m;
    logic [5:0] exp;
  } haz_vec_t;

  task automatic test_load_use();
    haz_vec_t v [9];
    //            rs    rt    a3e   a3m   trs   trt   tne   tnm  weE  weM  exp
    v[0] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, O_STALL}; // classic load/use
    v[1] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd2, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, O_RUN};   // tnew == tuse: forwardable
    v[2] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd1, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, O_STALL}; // tnew > tuse by one
    v[3] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0, O_RUN};   // E does not write
    v[4] = '{5'd5, 5'd0, 5'd6, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, O_RUN};   // register mismatch
    v[5] = '{5'd0, 5'd7, 5'd0, 5'd7, 2'd3, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, O_STALL}; // rt vs M stage
    v[6] = '{5'd0, 5'd7, 5'd0, 5'd7, 2'd3, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1, O_RUN};   // rt unused
    v[7] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd3, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, O_RUN};   // rs unused
    v[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b1, O_RUN};   // r0 match
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      rsD = v[i].rs; rtD = v[i].rt; A3E = v[i].a3e; A3M = v[i].a3m;
      tuseRsD = v[i].trs; tuseRtD = v[i].trt; tnewE = v[i].tne; tnewM = v[i].tnm;
      RegWriteE = v[i].we_e; RegWriteM = v[i].we_m;
      #1;
      checks++;
      if (outs() !== v[i].exp) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, outs(), v[i].exp);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_respon_override();
    idle_inputs();
    rsD = 5'd5; tuseRsD = 2'd0; A3E = 5'd5; tnewE = 2'd2; RegWriteE = 1'b1;
    respon = 1'b1;
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL respon_over_stall got=%b exp=%b", outs(), O_FLUSH);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mult_busy();
    idle_inputs();
    mdStartE = 1'b1; mdDivE = 1'b0; mdUseD = 1'b1;
    for (int c = 0; c < 7; c++) begin
      logic [5:0] exp;
      if (c == 0)      exp = MDU ? O_STALL : O_RUN;
      else if (c <= 5) exp = MDU ? with_busy(O_STALL, 1'b1) : O_RUN;
      else             exp = O_RUN;
      #1;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL mult_busy_cycle%0d got=%b exp=%b", c, outs(), exp);
      end
      tick();
      mdStartE = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_div();
    idle_inputs();
    mdStartE = 1'b1; mdDivE = 1'b1;
    tick();
    mdStartE = 1'b0; mdDivE = 1'b0;
    // Counter reads 10, 9, 8, 7 across these cycles.
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (outs() !== with_busy(O_RUN, MDU)) begin
        errors++;
        $display("FAIL div_busy_cycle%0d got=%b exp=%b", c, outs(), with_busy(O_RUN, MDU));
      end
      tick();
    end
    // Counter at 6: assert reset.
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL reset_mid_div got=%b exp=%b", outs(), O_FLUSH);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL after_reset_mid_div got=%b exp=%b", outs(), O_RUN);
    end
    tick();
  endtask

  task automatic test_respon_md();
    // Issue killed by respon: no load.
    idle_inputs();
    mdStartE = 1'b1; respon = 1'b1;
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL respon_start got=%b exp=%b", outs(), O_FLUSH);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL respon_start_no_load got=%b exp=%b", outs(), O_RUN);
    end
    // A running mult keeps counting through respon.
    mdStartE = 1'b1;
    tick();
    mdStartE = 1'b0;
    respon = 1'b1;
    #1;
    checks++;
    if (outs() !== with_busy(O_FLUSH, MDU)) begin
      errors++;
      $display("FAIL respon_during_count got=%b exp=%b", outs(), with_busy(O_FLUSH, MDU));
    end
    tick();
    respon = 1'b0;
    mdUseD = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [5:0] exp;
      exp = (MDU && c < 4) ? with_busy(O_STALL, 1'b1) : O_RUN;
      #1;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL count_after_respon%0d got=%b exp=%b", c, outs(), exp);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_respon_override();
    test_mult_busy();
    test_reset_mid_div();
    test_respon_md();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
